// File: rtl/cnn_pkg.sv
// Shared types and default geometry for the CNN scan/dense datapath.
// Provides the scan FSM state enum and default image/channel sizes.
package cnn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int IMG_W_DEF = 14;
  localparam int IMG_H_DEF = 14;
  localparam int CH_DEF    = 16;

endpackage

// File: rtl/scan_counter.sv
// Wrap-with-stride index counter: steps by `step`, wraps to 0 past `max`.
// Ports: clk, rst (sync, active-low), inc, clr, step, max -> value, wrap.
module scan_counter #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] step,
  input  logic [W-1:0] max,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] val_q, val_d;
  logic [W:0]   sum;

  // One extra bit so value+step cannot alias below max.
  assign sum  = {1'b0, val_q} + {1'b0, step};
  assign wrap = sum > {1'b0, max};

  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (inc) begin
      val_d = wrap ? '0 : sum[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign value = val_q;

endmodule

// File: rtl/scan_addr_gen.sv
// Scan controller: walks channel/row/col with stride, emits indices and a
// pair of image-memory read addresses over a valid/ready handshake.
// Ports: clk, rst (sync active-low), start, abort, out_ready ->
//   out_valid, row, col, channel, addr1, addr2, last, busy, done
//   [+ stall_cnt when SCAN_STALL_CNT_EN is defined].
module scan_addr_gen
  import cnn_pkg::*;
#(
  parameter int IMG_W    = IMG_W_DEF,
  parameter int IMG_H    = IMG_H_DEF,
  parameter int CH       = CH_DEF,
  parameter int STRIDE   = 1,
  parameter int PAIR_OFF = 2,
  parameter int ADDR_W   = 8,
  parameter int IDX_W    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  row,
  output logic [IDX_W-1:0]  col,
  output logic [IDX_W-1:0]  channel,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic              last,
  output logic              busy,
  output logic              done
`ifdef SCAN_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int COL_MAX = IMG_W - 1 - PAIR_OFF;
  localparam int ROW_MAX = IMG_H - 1;

  state_t state_q, state_d;
  logic   done_q, done_d;
  logic   run, hs, start_acc, clr_idx;
  logic   col_w, row_w, ch_w, is_last;

  assign run = (state_q == RUN);
  assign hs  = run & out_ready;

  // A start coinciding with the done pulse is deliberately dropped.
  assign start_acc = !run & start & !abort & !done_q;
  assign is_last   = col_w & row_w & ch_w;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    clr_idx = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_idx = 1'b1;
        if (start_acc) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          clr_idx = 1'b1;
        end else if (hs & is_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  scan_counter #(.W(IDX_W)) u_col (
    .clk   (clk),
    .rst   (rst),
    .inc   (hs),
    .clr   (clr_idx),
    .step  (IDX_W'(STRIDE)),
    .max   (IDX_W'(COL_MAX)),
    .value (col),
    .wrap  (col_w)
  );

  scan_counter #(.W(IDX_W)) u_row (
    .clk   (clk),
    .rst   (rst),
    .inc   (hs & col_w),
    .clr   (clr_idx),
    .step  (IDX_W'(STRIDE)),
    .max   (IDX_W'(ROW_MAX)),
    .value (row),
    .wrap  (row_w)
  );

  scan_counter #(.W(IDX_W)) u_ch (
    .clk   (clk),
    .rst   (rst),
    .inc   (hs & col_w & row_w),
    .clr   (clr_idx),
    .step  (IDX_W'(1)),
    .max   (IDX_W'(CH - 1)),
    .value (channel),
    .wrap  (ch_w)
  );

  // Indices are flops, so addresses depend on state only, never on out_ready.
  assign addr1 = ADDR_W'(32'(row) * 32'(IMG_W) + 32'(col));
  assign addr2 = addr1 + ADDR_W'(PAIR_OFF);

  assign out_valid = run;
  assign busy      = run;
  assign done      = done_q;
  assign last      = run & is_last;

`ifdef SCAN_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_acc) begin
      stall_d = '0;
    end else if (run & !out_ready & (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_scan_addr_gen.sv
// Self-checking bench for scan_addr_gen: default geometry plus a
// stride-2 single-channel instance, compared against a beat-list model.
module tb_scan_addr_gen;

  typedef struct {
    int r;
    int c;
    int ch;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic       start = 0, abort = 0, out_ready = 0;
  logic       out_valid, last, busy, done;
  logic [4:0] row, col, channel;
  logic [7:0] addr1, addr2;
  // Stride-2 instance
  logic       start_b = 0, abort_b = 0, out_ready_b = 1;
  logic       out_valid_b, last_b, busy_b, done_b;
  logic [4:0] row_b, col_b, channel_b;
  logic [7:0] addr1_b, addr2_b;
`ifdef SCAN_STALL_CNT_EN
  logic [15:0] stall_cnt, stall_cnt_b;
`endif

  scan_addr_gen u_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .row(row), .col(col), .channel(channel),
    .addr1(addr1), .addr2(addr2), .last(last),
    .busy(busy), .done(done)
`ifdef SCAN_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  scan_addr_gen #(.STRIDE(2), .CH(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .row(row_b), .col(col_b), .channel(channel_b),
    .addr1(addr1_b), .addr2(addr2_b), .last(last_b),
    .busy(busy_b), .done(done_b)
`ifdef SCAN_STALL_CNT_EN
    , .stall_cnt(stall_cnt_b)
`endif
  );

  int errors = 0;
  int checks = 0;
  beat_t qa[$];
  beat_t qb[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Enumerate the scan in plain loop order: channel, row, col.
  task automatic build(output beat_t q[$], input int w, input int h,
                       input int nch, input int s, input int po);
    beat_t b;
    q = {};
    for (int ch = 0; ch < nch; ch++)
      for (int r = 0; r <= h - 1; r += s)
        for (int c = 0; c <= w - 1 - po; c += s) begin
          b.r = r; b.c = c; b.ch = ch;
          q.push_back(b);
        end
  endtask

  function automatic int exp_addr(input beat_t b, input int w);
    return (b.r * w + b.c) % 256;
  endfunction

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, out_valid, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_last"}, last, 0);
    chk({nm, "_row"}, row, 0);
    chk({nm, "_col"}, col, 0);
    chk({nm, "_ch"}, channel, 0);
    chk({nm, "_a1"}, addr1, 0);
    chk({nm, "_a2"}, addr2, 2);
  endtask

  task automatic run_a(input int pct, input int abort_at, input bit hold);
    int  idx = 0;
    int  n = qa.size();
    int  cyc = 0;
    int  stalls = 0;
    bit  rdy;
    @(negedge clk);
    start = 1; out_ready = 0;
    @(negedge clk);
    if (!hold) start = 0;
`ifdef SCAN_STALL_CNT_EN
    chk("stall_clr", stall_cnt, 0);
`endif
    forever begin
      chk("valid", out_valid, 1);
      chk("busy", busy, 1);
      chk("done_run", done, 0);
      chk("row", row, qa[idx].r);
      chk("col", col, qa[idx].c);
      chk("ch", channel, qa[idx].ch);
      chk("addr1", addr1, exp_addr(qa[idx], 14));
      chk("addr2", addr2, (exp_addr(qa[idx], 14) + 2) % 256);
      chk("last", last, (idx == n - 1));
      if (idx == 12) chk("beat12_a1", addr1, 14);
      if (idx == n - 1) chk("lastbeat_a1", addr1, 193);
      if (idx == abort_at) begin
        abort = 1; out_ready = 1;
        @(negedge clk);
        abort = 0;
        chk_idle("abort");
        chk("abort_done", done, 0);
        @(negedge clk);
        chk("abort_done2", done, 0);
        return;
      end
      rdy = ($urandom_range(99) < pct);
      out_ready = rdy;
      if (!rdy) stalls++;
      @(negedge clk);
      cyc++;
      if (rdy) idx++;
      if (idx == n) break;
      if (cyc > n * 3 + 200) begin
        chk("timeout", idx, n);
        return;
      end
    end
    chk("done_pulse", done, 1);
    chk_idle("after_last");
`ifdef SCAN_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
`endif
    // Start during the done pulse must be ignored.
    start = 1;
    @(negedge clk);
    chk("done_clear", done, 0);
    chk("restart_ignored", out_valid, 0);
    start = hold;
    if (hold) begin
      @(negedge clk);
      start = 0;
      chk("restart_next", out_valid, 1);
      chk("restart_row", row, 0);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("restart_abort", out_valid, 0);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int cyc;
    build(qa, 14, 14, 16, 1, 2);
    build(qb, 14, 14, 1, 2, 2);
    chk("model_n", qa.size(), 2688);
    chk("model_b12_r", qa[12].r, 1);
    chk("model_b12_a", exp_addr(qa[12], 14), 14);
    chk("model_last_a", exp_addr(qa[2687], 14), 193);
    chk("model_last_ch", qa[2687].ch, 15);
    chk("model_bn", qb.size(), 42);
    chk("model_b_last", exp_addr(qb[41], 14), 178);

    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_done", done, 0);
    rst = 1;
    @(negedge clk);

    run_a(100, -1, 0);
    run_a(50, -1, 0);
    run_a(100, -1, 1);
    run_a(70, 100, 0);
    run_a(100, 5, 0);

    // Reset mid-scan with start held.
    start = 1; out_ready = 1;
    repeat (50) @(negedge clk);
    chk("pre_rst_valid", out_valid, 1);
    rst = 0;
    @(negedge clk);
    chk_idle("midrst");
    chk("midrst_done", done, 0);
    rst = 1; start = 0;
    @(negedge clk);
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_done", done, 0);

    // Abort together with start in IDLE stays idle.
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0;
    chk("abort_start_idle", out_valid, 0);

    // Stride-2 single-channel instance.
    start_b = 1;
    @(negedge clk);
    start_b = 0;
    nb = 0; cyc = 0;
    while (cyc < 200) begin
      if (out_valid_b) begin
        if (nb < qb.size()) begin
          chk("b_row", row_b, qb[nb].r);
          chk("b_col", col_b, qb[nb].c);
          chk("b_ch", channel_b, 0);
          chk("b_a1", addr1_b, exp_addr(qb[nb], 14));
          chk("b_a2", addr2_b, exp_addr(qb[nb], 14) + 2);
          chk("b_last", last_b, (nb == qb.size() - 1));
          if (nb == 41) chk("b_last_a1", addr1_b, 178);
        end
        nb++;
      end else if (nb > 0) begin
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("b_beats", nb, 42);
    chk("b_done", done_b, 1);
    @(negedge clk);
    chk("b_done_clr", done_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
